// File: rtl/fir_stream_ctrl.sv
// Streaming byte front/back-end for the fir HLS core: sequences ap_ctrl_hs per
// input sample, buffers 16-bit results and returns them as byte pairs.
module fir_stream_ctrl #(
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        fir_rst,
  output logic        fir_start,
  output logic [7:0]  fir_x,
  input  logic        fir_ready,
  input  logic        fir_done,
  input  logic        fir_idle,
  input  logic [15:0] fir_y,
  input  logic        fir_y_vld,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        busy,
  output logic        ovf,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never waits on ready, and data is held while valid & ~ready.

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [1:0]    rst_sync;
  logic          s_accept;
  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          byte_sel;
  logic          full, push_req, push, pop;
  logic [15:0]   head;
  logic [7:0]    first_byte, second_byte;

  // Core reset asserts immediately, releases on the 2nd edge after ap_rst_n rises.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  assign fir_rst = ~rst_sync[1];

  assign full    = (count == DEPTH_C);
  assign s_ready = (state == IDLE) & ~fir_rst & (count < DEPTH_C);

  always_comb begin
    state_next = state;
    s_accept   = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid && s_ready) begin
          s_accept   = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (fir_ready) state_next = fir_done ? IDLE : WAIT;
      end
      WAIT: begin
        if (fir_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (fir_rst) state_next = IDLE;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      fir_start <= 1'b0;
      fir_x     <= 8'h00;
    end else begin
      state     <= state_next;
      fir_start <= (state_next == START);
      if (s_accept) fir_x <= s_data;
    end
  end

  // Results are captured whenever the core flags them, regardless of FSM state.
  assign push_req = fir_y_vld & ~fir_rst;
  assign pop      = m_valid & m_ready & byte_sel;
  assign push     = push_req & (~full | pop);

  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr] <= fir_y;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      byte_sel <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (m_valid && m_ready) byte_sel <= ~byte_sel;
      if (push_req && full && !pop) ovf <= 1'b1;
    end
  end

  assign head        = mem[rd_ptr];
  assign first_byte  = MSB_FIRST ? head[15:8] : head[7:0];
  assign second_byte = MSB_FIRST ? head[7:0]  : head[15:8];

  assign m_valid   = (count != '0);
  assign m_data    = m_valid ? (byte_sel ? second_byte : first_byte) : 8'h00;
  assign busy      = (state != IDLE) | ~fir_idle;
  assign dbg_state = state;

endmodule
